// File: rtl/shapool_job_ctrl.sv
// rtl/shapool_job_ctrl.sv - job/result controller between external_io and the shapool hasher pool
//
// Ports:
//   clk_in, reset_in        clock, asynchronous active-high reset
//   job_in/job_valid_in     job offer; job_ready_out high while the pending slot is empty
//   stop_on_success_in      end a job at its first success instead of sweeping the nonce space
//   abort_in                abandon the active job (no result pushed)
//   job_out                 active job word driven to the pool (held until the next load)
//   core_reset_out          active-high pool reset, low only while a job runs
//   core_step_in            one pulse per nonce evaluated by the pool
//   core_success_in         success strobe, core_nonce_in valid with it
//   result_out/valid/ack    head of the result FIFO {tag, nonce}, pop on ack
//   busy_out                a job is loading or running
//   job_done_out            one-cycle pulse after a job ends
//   exhausted_out           sticky: a job ended by sweeping the full nonce space
//   overflow_out            sticky: a result was dropped because the FIFO was full
//   clear_in                clears the two sticky flags

module shapool_job_ctrl #(
    parameter int JOB_WIDTH       = 360,
    parameter int NONCE_WIDTH     = 31,
    parameter int TAG_WIDTH       = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                           clk_in,
    input  logic                           reset_in,
    input  logic [JOB_WIDTH-1:0]           job_in,
    input  logic                           job_valid_in,
    output logic                           job_ready_out,
    input  logic                           stop_on_success_in,
    input  logic                           abort_in,
    output logic [JOB_WIDTH-1:0]           job_out,
    output logic                           core_reset_out,
    input  logic                           core_step_in,
    input  logic                           core_success_in,
    input  logic [NONCE_WIDTH-1:0]         core_nonce_in,
    output logic [TAG_WIDTH+NONCE_WIDTH-1:0] result_out,
    output logic                           result_valid_out,
    input  logic                           result_ack_in,
    output logic                           busy_out,
    output logic                           job_done_out,
    output logic                           exhausted_out,
    output logic                           overflow_out,
    input  logic                           clear_in
);

    localparam logic [FIFO_DEPTH_LOG2:0] C_FIFO_FULL = (FIFO_DEPTH_LOG2+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Pending slot and tag generation
    logic                 r_pend_valid;
    logic [JOB_WIDTH-1:0] r_pend_job;
    logic [TAG_WIDTH-1:0] r_pend_tag;
    logic [TAG_WIDTH-1:0] r_tag_cnt;

    // Active job
    logic [JOB_WIDTH-1:0] r_job;
    logic [TAG_WIDTH-1:0] r_active_tag;
    logic [NONCE_WIDTH:0] r_step;

    // Result FIFO
    logic [TAG_WIDTH+NONCE_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]       r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]       r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]         r_count;

    // Status
    logic r_done;
    logic r_exhausted;
    logic r_overflow;

    logic                 w_run;
    logic                 w_load;
    logic                 w_accept;
    logic [NONCE_WIDTH:0] w_step_next;
    logic                 w_exhaust;
    logic                 w_push;
    logic                 w_end;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push_ok;
    logic                 w_drop;

    assign w_run       = (r_state == ST_RUN);
    assign w_load      = (r_state == ST_LOAD);
    assign w_accept    = job_valid_in & ~r_pend_valid;
    assign w_step_next = r_step + 1'b1;

    // Abort beats everything: it suppresses both the push and the exhaustion flag.
    assign w_exhaust = w_run & ~abort_in & core_step_in & w_step_next[NONCE_WIDTH];
    assign w_push    = w_run & ~abort_in & core_success_in;
    assign w_end     = w_run & (abort_in | w_exhaust | (w_push & stop_on_success_in));

    // A push into a full FIFO still lands when the head is popped in the same cycle.
    assign w_pop     = result_ack_in & (r_count != '0);
    assign w_full    = (r_count == C_FIFO_FULL);
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    assign job_ready_out    = ~r_pend_valid;
    assign job_out          = r_job;
    assign result_out       = r_mem[r_rd_ptr];
    assign result_valid_out = (r_count != '0);
    assign job_done_out     = r_done;
    assign exhausted_out    = r_exhausted;
    assign overflow_out     = r_overflow;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        core_reset_out = 1'b1;
        busy_out       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend_valid) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy_out     = 1'b1;
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                busy_out       = 1'b1;
                core_reset_out = 1'b0;
                if (w_end) begin
                    w_next_state = r_pend_valid ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_pend_valid <= 1'b0;
            r_pend_job   <= '0;
            r_pend_tag   <= '0;
            r_tag_cnt    <= '0;
        end else if (w_load) begin
            r_pend_valid <= 1'b0;
        end else if (w_accept) begin
            r_pend_valid <= 1'b1;
            r_pend_job   <= job_in;
            r_pend_tag   <= r_tag_cnt;
            r_tag_cnt    <= r_tag_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_job        <= '0;
            r_active_tag <= '0;
            r_step       <= '0;
        end else if (w_load) begin
            r_job        <= r_pend_job;
            r_active_tag <= r_pend_tag;
            r_step       <= '0;
        end else if (w_run && core_step_in) begin
            r_step <= w_step_next;
        end
    end

    // Storage is not reset; only the pointers and count define FIFO contents.
    always_ff @(posedge clk_in) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {r_active_tag, core_nonce_in};
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Setting a sticky flag wins over a simultaneous clear.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_done      <= 1'b0;
            r_exhausted <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done      <= w_end;
            r_exhausted <= (r_exhausted & ~clear_in) | w_exhaust;
            r_overflow  <= (r_overflow & ~clear_in) | w_drop;
        end
    end

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// tb/tb_shapool_job_ctrl.sv - bench for shapool_job_ctrl

module tb_shapool_job_ctrl;

    localparam int JW = 64;
    localparam int NW = 4;
    localparam int TW = 4;
    localparam int RW = TW + NW;
    localparam int NSPACE = 1 << NW;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic [JW-1:0] job_in;
    logic          job_valid_in;
    logic          job_ready_out;
    logic          stop_on_success_in;
    logic          abort_in;
    logic [JW-1:0] job_out;
    logic          core_reset_out;
    logic          core_step_in;
    logic          core_success_in;
    logic [NW-1:0] core_nonce_in;
    logic [RW-1:0] result_out;
    logic          result_valid_out;
    logic          result_ack_in;
    logic          busy_out;
    logic          job_done_out;
    logic          exhausted_out;
    logic          overflow_out;
    logic          clear_in;

    int checks = 0;
    int fails  = 0;
    int m_tag  = 0;

    shapool_job_ctrl #(
        .JOB_WIDTH(JW), .NONCE_WIDTH(NW), .TAG_WIDTH(TW),
        .FIFO_DEPTH(4), .FIFO_DEPTH_LOG2(2)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .job_in(job_in), .job_valid_in(job_valid_in), .job_ready_out(job_ready_out),
        .stop_on_success_in(stop_on_success_in), .abort_in(abort_in),
        .job_out(job_out), .core_reset_out(core_reset_out),
        .core_step_in(core_step_in), .core_success_in(core_success_in),
        .core_nonce_in(core_nonce_in),
        .result_out(result_out), .result_valid_out(result_valid_out),
        .result_ack_in(result_ack_in),
        .busy_out(busy_out), .job_done_out(job_done_out),
        .exhausted_out(exhausted_out), .overflow_out(overflow_out),
        .clear_in(clear_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic quiet();
        job_valid_in = 0; core_step_in = 0; core_success_in = 0; abort_in = 0;
        result_ack_in = 0; clear_in = 0; core_nonce_in = '0;
    endtask

    function automatic logic [JW-1:0] rand_job();
        return {$urandom(), $urandom()};
    endfunction

    // Offer a job into an idle controller and wait for it to reach RUN.
    task automatic start_job(input logic [JW-1:0] j, output logic [TW-1:0] tag);
        int n;
        n = 0;
        while (!job_ready_out && n < 50) begin tick(); n++; end
        job_in = j; job_valid_in = 1; tick(); job_valid_in = 0;
        n = 0;
        while (core_reset_out && n < 50) begin tick(); n++; end
        tag = TW'(m_tag);
        m_tag = (m_tag + 1) % (1 << TW);
        checks++;
        if (core_reset_out !== 1'b0 || job_out !== j || busy_out !== 1'b1) begin
            fails++;
            $display("FAIL start_job: core_reset_out=%b job_out=%h busy=%b, required 0 %h 1", core_reset_out, job_out, busy_out, j);
        end
    endtask

    task automatic test_reset();
        quiet(); stop_on_success_in = 0; job_in = '0;
        reset_in = 1; tick(); tick();
        checks++;
        if (job_ready_out !== 1 || core_reset_out !== 1 || result_valid_out !== 0 || busy_out !== 0 ||
            job_done_out !== 0 || exhausted_out !== 0 || overflow_out !== 0 || job_out !== '0) begin
            fails++;
            $display("FAIL reset_state: ready=%b core_reset=%b rvalid=%b busy=%b done=%b exh=%b ovf=%b job=%h",
                     job_ready_out, core_reset_out, result_valid_out, busy_out, job_done_out, exhausted_out, overflow_out, job_out);
        end
        reset_in = 0; m_tag = 0; tick();
    endtask

    task automatic test_exhaust();
        logic [TW-1:0] t;
        start_job(rand_job(), t);
        stop_on_success_in = 0;
        for (int i = 0; i < NSPACE; i++) begin
            core_step_in = 1;
            clear_in = (i == NSPACE - 1);
            tick();
            if (i < NSPACE - 1) begin
                checks++;
                if (core_reset_out !== 0 || job_done_out !== 0) begin
                    fails++;
                    $display("FAIL exhaust_running step %0d: core_reset=%b done=%b, required 0 0", i, core_reset_out, job_done_out);
                end
            end
        end
        quiet();
        checks++;
        if (job_done_out !== 1 || exhausted_out !== 1 || core_reset_out !== 1 || busy_out !== 0) begin
            fails++;
            $display("FAIL exhaust_end: done=%b exh=%b core_reset=%b busy=%b, required 1 1 1 0", job_done_out, exhausted_out, core_reset_out, busy_out);
        end
        tick();
        checks++;
        if (job_done_out !== 0) begin
            fails++;
            $display("FAIL exhaust_done_pulse: done=%b, required 0", job_done_out);
        end
        clear_in = 1; tick(); clear_in = 0;
        checks++;
        if (exhausted_out !== 0) begin
            fails++;
            $display("FAIL exhaust_clear: exh=%b, required 0", exhausted_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [TW-1:0] ta, tb;
        logic [JW-1:0] jb;
        jb = rand_job();
        start_job(rand_job(), ta);
        job_in = jb; job_valid_in = 1; tick(); job_valid_in = 0;
        tb = TW'(m_tag); m_tag = (m_tag + 1) % (1 << TW);
        checks++;
        if (job_ready_out !== 0) begin
            fails++;
            $display("FAIL b2b_ready: ready=%b, required 0", job_ready_out);
        end
        stop_on_success_in = 1; core_success_in = 1; core_nonce_in = 4'h5; tick(); quiet();
        checks++;
        if (job_done_out !== 1 || result_valid_out !== 1 || result_out !== {ta, 4'h5} || core_reset_out !== 1 || busy_out !== 1) begin
            fails++;
            $display("FAIL b2b_success: done=%b rvalid=%b result=%h core_reset=%b busy=%b, required 1 1 %h 1 1",
                     job_done_out, result_valid_out, result_out, core_reset_out, busy_out, {ta, 4'h5});
        end
        result_ack_in = 1; tick(); quiet();
        checks++;
        if (job_out !== jb || core_reset_out !== 0 || result_valid_out !== 0 || job_ready_out !== 1) begin
            fails++;
            $display("FAIL b2b_load: job=%h core_reset=%b rvalid=%b ready=%b, required %h 0 0 1", job_out, core_reset_out, result_valid_out, job_ready_out, jb);
        end
        core_success_in = 1; core_nonce_in = 4'hC; tick(); quiet();
        checks++;
        if (result_out !== {tb, 4'hC} || job_done_out !== 1) begin
            fails++;
            $display("FAIL b2b_tag: result=%h done=%b, required %h 1", result_out, job_done_out, {tb, 4'hC});
        end
        result_ack_in = 1; tick(); quiet(); stop_on_success_in = 0;
    endtask

    task automatic test_overflow();
        logic [TW-1:0] t;
        start_job(rand_job(), t);
        for (int n = 1; n <= 5; n++) begin
            core_success_in = 1; core_nonce_in = NW'(n); tick();
            checks++;
            if (result_valid_out !== 1 || overflow_out !== (n == 5)) begin
                fails++;
                $display("FAIL overflow_fill %0d: rvalid=%b ovf=%b, required 1 %b", n, result_valid_out, overflow_out, n == 5);
            end
        end
        quiet(); abort_in = 1; tick(); quiet();
        for (int n = 1; n <= 4; n++) begin
            checks++;
            if (result_out !== {t, NW'(n)}) begin
                fails++;
                $display("FAIL overflow_drain %0d: result=%h, required %h", n, result_out, {t, NW'(n)});
            end
            result_ack_in = 1; tick(); quiet();
        end
        checks++;
        if (result_valid_out !== 0) begin
            fails++;
            $display("FAIL overflow_empty: rvalid=%b, required 0", result_valid_out);
        end
        clear_in = 1; tick(); quiet();
        checks++;
        if (overflow_out !== 0) begin
            fails++;
            $display("FAIL overflow_clear: ovf=%b, required 0", overflow_out);
        end
    endtask

    task automatic test_full_push_pop();
        logic [TW-1:0] t;
        start_job(rand_job(), t);
        for (int n = 6; n <= 9; n++) begin
            core_success_in = 1; core_nonce_in = NW'(n); tick();
        end
        core_success_in = 1; core_nonce_in = 4'hA; result_ack_in = 1;
        checks++;
        if (result_out !== {t, 4'h6}) begin
            fails++;
            $display("FAIL pushpop_head: result=%h, required %h", result_out, {t, 4'h6});
        end
        tick(); quiet();
        checks++;
        if (overflow_out !== 0 || result_out !== {t, 4'h7}) begin
            fails++;
            $display("FAIL pushpop_after: ovf=%b result=%h, required 0 %h", overflow_out, result_out, {t, 4'h7});
        end
        abort_in = 1; tick(); quiet();
        for (int n = 7; n <= 10; n++) begin
            checks++;
            if (result_valid_out !== 1 || result_out !== {t, NW'(n)}) begin
                fails++;
                $display("FAIL pushpop_drain %0d: rvalid=%b result=%h, required 1 %h", n, result_valid_out, result_out, {t, NW'(n)});
            end
            result_ack_in = 1; tick(); quiet();
        end
        checks++;
        if (result_valid_out !== 0) begin
            fails++;
            $display("FAIL pushpop_empty: rvalid=%b, required 0", result_valid_out);
        end
    endtask

    task automatic test_priority();
        logic [TW-1:0] t;
        for (int pass = 0; pass < 2; pass++) begin
            start_job(rand_job(), t);
            for (int i = 0; i < NSPACE - 1; i++) begin core_step_in = 1; tick(); end
            core_step_in = 1; core_success_in = 1; core_nonce_in = 4'h9; abort_in = (pass == 0);
            tick(); quiet();
            checks++;
            if (job_done_out !== 1 || exhausted_out !== (pass == 1) || result_valid_out !== (pass == 1) || core_reset_out !== 1) begin
                fails++;
                $display("FAIL priority pass %0d: done=%b exh=%b rvalid=%b core_reset=%b, required 1 %b %b 1",
                         pass, job_done_out, exhausted_out, result_valid_out, core_reset_out, pass == 1, pass == 1);
            end
            if (pass == 1) begin
                checks++;
                if (result_out !== {t, 4'h9}) begin
                    fails++;
                    $display("FAIL priority_result: result=%h, required %h", result_out, {t, 4'h9});
                end
                result_ack_in = 1; clear_in = 1; tick(); quiet();
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [TW-1:0] t;
        start_job(rand_job(), t);
        core_success_in = 1; core_nonce_in = 4'h1; tick();
        core_nonce_in = 4'h2; tick(); quiet();
        job_in = rand_job(); job_valid_in = 1; tick(); job_valid_in = 0;
        #2 reset_in = 1;
        #1;
        checks++;
        if (result_valid_out !== 0 || job_ready_out !== 1 || core_reset_out !== 1 || busy_out !== 0 || job_out !== '0) begin
            fails++;
            $display("FAIL midrun_reset: rvalid=%b ready=%b core_reset=%b busy=%b job=%h, required 0 1 1 0 0",
                     result_valid_out, job_ready_out, core_reset_out, busy_out, job_out);
        end
        tick(); reset_in = 0; m_tag = 0; tick();
        start_job(rand_job(), t);
        core_success_in = 1; core_nonce_in = 4'h7; tick(); quiet();
        checks++;
        if (result_out !== {4'h0, 4'h7} || result_valid_out !== 1) begin
            fails++;
            $display("FAIL midrun_tag: result=%h rvalid=%b, required 07 1", result_out, result_valid_out);
        end
        abort_in = 1; result_ack_in = 1; tick(); quiet();
    endtask

    // Transaction-level model: a queue of expected results, a step count and sticky flags.
    task automatic test_random();
        logic [RW-1:0] m_q[$];
        logic [TW-1:0] t;
        bit m_exh, m_ovf, stop, step, succ, ack, abrt, pop, ended, full;
        logic [NW-1:0] nonce;
        int steps, n;
        for (int job = 0; job < 8; job++) begin
            clear_in = 1; tick(); quiet();
            m_exh = 0; m_ovf = 0; steps = 0; ended = 0; n = 0;
            stop = ($urandom_range(0, 2) == 0);
            stop_on_success_in = stop;
            start_job(rand_job(), t);
            while (!ended && n < 300) begin
                step = $urandom_range(0, 1); succ = ($urandom_range(0, 5) == 0);
                ack = ($urandom_range(0, 2) == 0); abrt = ($urandom_range(0, 60) == 0);
                nonce = NW'($urandom());
                core_step_in = step; core_success_in = succ; core_nonce_in = nonce;
                result_ack_in = ack; abort_in = abrt;
                pop = ack && m_q.size() > 0;
                full = (m_q.size() == 4);
                if (pop) begin
                    checks++;
                    if (result_out !== m_q[0]) begin
                        fails++;
                        $display("FAIL random_pop job %0d: result=%h, required %h", job, result_out, m_q[0]);
                    end
                    void'(m_q.pop_front());
                end
                if (succ && !abrt) begin
                    if (!full || pop) m_q.push_back({t, nonce});
                    else m_ovf = 1;
                end
                if (!abrt && step && steps + 1 == NSPACE) m_exh = 1;
                ended = abrt || m_exh || (succ && stop);
                if (step) steps++;
                tick(); quiet();
                n++;
                checks++;
                if (job_done_out !== ended || result_valid_out !== (m_q.size() > 0)) begin
                    fails++;
                    $display("FAIL random_cycle job %0d: done=%b rvalid=%b, required %b %b", job, job_done_out, result_valid_out, ended, m_q.size() > 0);
                end
            end
            checks++;
            if (!ended || exhausted_out !== m_exh || overflow_out !== m_ovf) begin
                fails++;
                $display("FAIL random_end job %0d: ended=%b exh=%b ovf=%b, required 1 %b %b", job, ended, exhausted_out, overflow_out, m_exh, m_ovf);
            end
            while (m_q.size() > 0) begin
                checks++;
                if (result_out !== m_q[0]) begin
                    fails++;
                    $display("FAIL random_drain job %0d: result=%h, required %h", job, result_out, m_q[0]);
                end
                void'(m_q.pop_front());
                result_ack_in = 1; tick(); quiet();
            end
            checks++;
            if (result_valid_out !== 0) begin
                fails++;
                $display("FAIL random_empty job %0d: rvalid=%b, required 0", job, result_valid_out);
            end
        end
        stop_on_success_in = 0;
    endtask

    initial begin
        test_reset();
        test_exhaust();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_priority();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/shapool_job_ctrl.md
Name: shapool_job_ctrl

Overview:
- Parametrised job/result controller between external_io and the shapool hasher pool.
- Double-buffers jobs: one active, one pending. Holds the core in reset between jobs. Tags each job.
- Detects nonce-space exhaustion and queues winning nonces in a result FIFO.
- Supports back-to-back jobs and multiple results per job, with no host round-trip per job.

Parameters:
JOB_WIDTH, 360, width of job word {sha_state, message_head, difficulty}
NONCE_WIDTH, 31, core nonce width (32 - POOL_SIZE_LOG2)
TAG_WIDTH, 4, job tag width
FIFO_DEPTH, 4, result FIFO entries (power of 2)
FIFO_DEPTH_LOG2, 2, log2(FIFO_DEPTH)

Ports:
clk_in  input  1  system clock
reset_in  input  1  asynchronous active-high reset
job_in  input  JOB_WIDTH  job word from external_io
job_valid_in  input  1  job offered
job_ready_out  output  1  pending slot empty; job accepted when valid&ready
stop_on_success_in  input  1  1: end job at first success; 0: sweep full nonce space
abort_in  input  1  abandon active job
job_out  output  JOB_WIDTH  active job to shapool
core_reset_out  output  1  active-high core reset (top inverts for shapool)
core_step_in  input  1  one pulse per nonce evaluated by pool
core_success_in  input  1  pool success strobe
core_nonce_in  input  NONCE_WIDTH  pool nonce, valid with success
result_out  output  TAG_WIDTH+NONCE_WIDTH  FIFO head {tag, nonce}
result_valid_out  output  1  FIFO non-empty (drives ready_n tristate/LED)
result_ack_in  input  1  pop FIFO head
busy_out  output  1  state is LOAD or RUN
job_done_out  output  1  1-cycle pulse when a job ends (success-stop, exhaustion or abort)
exhausted_out  output  1  sticky: last job ended by exhaustion
overflow_out  output  1  sticky: a result was dropped on a full FIFO
clear_in  input  1  clears exhausted_out, overflow_out

Behaviour:
- Reset: state IDLE, pending empty, tag counter 0, FIFO empty, job_out 0, core_reset_out 1, all status outputs 0. job_ready_out is 1 after reset.
- Pending slot:
  - Accept on job_valid_in & job_ready_out. Store job plus tag (tag counter value, then tag counter +1 mod 2^TAG_WIDTH).
  - job_ready_out = ~pending_valid. Acceptance and transfer to active in the same cycle is allowed: the slot frees next cycle.
- FSM:
  - IDLE: core_reset_out=1. Moves to LOAD when pending_valid.
  - LOAD, 1 cycle:
    - job_out<=pending job; active_tag<=pending tag; pending_valid<=0; step counter<=0.
    - core_reset_out=1. Moves to RUN.
  - RUN: core_reset_out=0.
    - core_step_in increments the NONCE_WIDTH+1-bit step counter.
    - Exhaustion when the counter reaches 2^NONCE_WIDTH, i.e. the MSB sets. The job then ends: exhausted_out<=1, job_done_out pulse.
    - core_success_in pushes {active_tag, core_nonce_in}. If stop_on_success_in=1 the job ends.
    - abort_in ends the job with no push.
    - After a job ends: if pending_valid, go to LOAD, else IDLE. core_reset_out=1 from the cycle after the end event.
  - abort_in in IDLE/LOAD is ignored. A job loaded in LOAD always enters RUN.
- Priority in the same RUN cycle: abort > success push > exhaustion.
  - Success with abort: no push.
  - Success with exhaustion: push, then end; exhausted_out set.
- core_success_in outside RUN is ignored.
- FIFO:
  - Pop on result_ack_in & result_valid_out. A push while full and not popping is dropped: overflow_out<=1, contents unchanged.
  - Push and pop in the same cycle while full: both occur, count unchanged.
  - result_out is valid combinationally from the head pointer. result_ack_in while empty has no effect.
- clear_in clears the sticky flags. If exhaustion occurs in the same cycle, exhausted_out is set (set wins).
- job_out holds its value after a job ends until the next LOAD.
- Reset asserted mid-RUN: everything returns to reset values immediately, including the FIFO and pending slot.

Test Plan:
1. NONCE_WIDTH=4: accept job A (tag 0), stop_on_success=0, 16 core_step_in pulses, no success -> core_reset_out 0 for 16+ cycles, then job_done_out pulse, exhausted_out=1, state IDLE, core_reset_out=1.
2. Job A running, job B offered -> job_ready_out drops to 0. A succeeds with nonce 0x5, stop_on_success=1 -> result {0,0x5}. LOAD of B next cycle; B's tag is 1, and job_out equals B.
3. stop_on_success=0, FIFO_DEPTH=4, 5 successes (nonces 1..5), no acks -> FIFO holds 1..4, overflow_out=1. 4 acks -> results in order, then result_valid_out=0.
4. FIFO full, success and result_ack_in in the same cycle -> head popped, new nonce appended, overflow_out stays 0.
5. Same cycle success (nonce 0x9), 16th step and abort_in -> no push, job_done_out pulse, exhausted_out=0. The same case without abort -> push {tag,0x9} and exhausted_out=1.
6. reset_in asserted mid-RUN with 2 FIFO entries and a pending job -> result_valid_out=0, job_ready_out=1, core_reset_out=1, next accepted job gets tag 0.
